bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Two-master arbiter for the shared system bus in front of the slave address decoder.
//  Masters: M0 (host/testbench port) and M1 (factorial core).
//  Grants exactly one master at a time and drives the master-side mux select.
//  The granted master's address/data then reach slaves S0..S2 through the decoder.
// PARAMETERS
//  TIMEOUT_CYC  16  max consecutive grant cycles before a forced handover (ARB_TIMEOUT_EN only)
//  CNT_W         5  width of the hold counter; must satisfy 2**CNT_W > TIMEOUT_CYC
// PORTS
//  clk       in   1  system clock, rising edge
//  reset_n   in   1  asynchronous active-low reset
//  M0_req    in   1  master 0 bus request, level; held for the whole transfer
//  M1_req    in   1  master 1 bus request, level; held for the whole transfer
//  M0_grant  out  1  master 0 owns the bus (registered)
//  M1_grant  out  1  master 1 owns the bus (registered)
//  m_sel     out  1  bus mux select: 0 = M0 drives, 1 = M1 drives (registered)
//  bus_busy  out  1  asserted while either grant is high
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, M0_grant=0, M1_grant=0, m_sel=0, bus_busy=0, last=M1, cnt=0.
//  FSM states: IDLE, GNT_M0, GNT_M1; encoded 2'b00 / 2'b01 / 2'b10. Grants are Moore outputs of the state.
//  Latency: a request sampled at edge N raises its grant after edge N. No combinational req->grant path.
//  IDLE:
//   - exactly one req high -> grant that master;
//   - both high -> grant the master that is not 'last' (round-robin);
//   - none -> stay IDLE.
//  GNT_Mx, own req high -> stay (no preemption without ARB_TIMEOUT_EN).
//  GNT_Mx, own req low:
//   - other req high -> go directly to GNT_other (no idle cycle);
//   - otherwise -> IDLE.
//  'last' updates to x on every entry into GNT_Mx.
//  m_sel:
//   - follows the granted master;
//   - holds its previous value in IDLE (keeps bus lines stable).
//  Invariant: M0_grant & M1_grant == 0 in every cycle, including across reset.
//  Request dropped and re-raised in the same cycle as a handover: evaluated from the sampled level only.
//  Reset mid-transfer drops all grants immediately (async). The master re-requests after reset release.
//  cnt:
//   - clears on every state change;
//   - increments each cycle in GNT_*;
//   - saturates at 2**CNT_W-1.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - in GNT_Mx with the other req high and cnt==TIMEOUT_CYC-1, the next state is GNT_other even though req_x is high;
//   - the preempted master keeps its req high and is re-granted via round-robin.
//  ARB_TIMEOUT_EN undefined:
//   - no preemption; the counter logic is not compiled;
//   - a master may hold the bus indefinitely.
// STRUCTURE
//  Shared header bus_defines.vh holds:
//   - state encodings ARB_IDLE/ARB_GNT_M0/ARB_GNT_M1;
//   - master index constants;
//   - the slave address map constants also used by the address decoder.
//  One sub-module, arb_hold_counter (clear, enable, saturate, terminal-count flag), instantiated only under ARB_TIMEOUT_EN.
//  The FSM and output registers stay in bus_arbiter.
// TESTING
//  1. Hold reset_n=0, then release -> all outputs 0, state IDLE, m_sel=0.
//  2. M1_req=1 at edge 3, held 4 cycles -> M1_grant=1 after edge 3, m_sel=1; drop req -> IDLE, m_sel stays 1.
//  3. M0_req and M1_req both rise at the same edge from reset -> M0 granted first (last=M1);
//     M0 drops -> M1 granted on the next edge with no idle cycle.
//  4. Both masters toggle back-to-back 10 transfers -> grants strictly alternate; never both high (assertion every cycle).
//  5. ARB_TIMEOUT_EN, TIMEOUT_CYC=4: M0 holds req, M1 requests -> M0_grant high exactly 4 cycles, then M1_grant;
//     without the macro M0 holds indefinitely.
//  6. Pull reset_n low mid-GNT_M1 between clock edges -> M1_grant falls without a clock edge; IDLE after release.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the system bus arbiter and the slave address decoder.
//   - arbiter state encodings (ARB_IDLE / ARB_GNT_M0 / ARB_GNT_M1)
//   - master index constants used for the round-robin 'last' marker
//   - hold-counter sizing used when ARB_TIMEOUT_EN is defined
//   - slave address map (S0..S2) and a small decode helper
// No ports; imported with import bus_arbiter_pkg::*.
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

   // Maximum consecutive grant cycles before a forced handover.
   localparam int TIMEOUT_CYC = 16;
   // Hold counter width; 2**CNT_W must exceed TIMEOUT_CYC.
   localparam int CNT_W = 5;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'b00,
      ARB_GNT_M0 = 2'b01,
      ARB_GNT_M1 = 2'b10
   } arb_state_e;

   localparam logic MST_M0 = 1'b0;
   localparam logic MST_M1 = 1'b1;

   // Slave address map shared with the address decoder.
   localparam logic [15:0] S0_BASE = 16'h0000;
   localparam logic [15:0] S1_BASE = 16'h4000;
   localparam logic [15:0] S2_BASE = 16'h8000;
   localparam logic [15:0] SLV_MASK = 16'hC000;

   // Returns the slave index for an address; 2'd3 means unmapped.
   function automatic logic [1:0] slave_index(input logic [15:0] addr);
      logic [15:0] region;
      region = addr & SLV_MASK;
      if (region == S0_BASE) return 2'd0;
      else if (region == S1_BASE) return 2'd1;
      else if (region == S2_BASE) return 2'd2;
      else return 2'd3;
   endfunction

endpackage

// File: rtl/arb_hold_counter.sv
// ---------------------------------------------------------------------------
// arb_hold_counter
// Counts consecutive cycles a master has held the bus. Clear wins over
// enable; the count saturates at all-ones so it never wraps back to a value
// that could look like a fresh grant.
// Ports:
//   clk      in  system clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   clear    in  synchronous clear (state change)
//   enable   in  count this cycle (a grant is active)
//   tc       out terminal count reached (cnt == TC_VAL)
// ---------------------------------------------------------------------------
module arb_hold_counter #(
   parameter int CNT_W  = 5,
   parameter int TC_VAL = 15
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == CNT_W'(TC_VAL));

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Two-master arbiter for the shared system bus. M0 is the host port, M1 the
// factorial core. Exactly one master is granted at a time; grants and the
// mux select are registered, so a request sampled at an edge shows up as a
// grant just after that edge. Contention from IDLE is resolved round-robin
// against the last master granted. A releasing master hands over directly
// to a waiting master without an idle cycle.
// Optional feature: define ARB_TIMEOUT_EN to force a handover after
// TIMEOUT_CYC consecutive grant cycles when the other master is waiting.
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   M0_req    in   master 0 request (level)
//   M1_req    in   master 1 request (level)
//   M0_grant  out  master 0 owns the bus (registered)
//   M1_grant  out  master 1 owns the bus (registered)
//   m_sel     out  bus mux select, 0 = M0, 1 = M1 (registered)
//   bus_busy  out  either grant is high
// ---------------------------------------------------------------------------
module bus_arbiter
   import bus_arbiter_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic M0_req,
   input  logic M1_req,
   output logic M0_grant,
   output logic M1_grant,
   output logic m_sel,
   output logic bus_busy
);

   arb_state_e state_q, state_d;
   logic       last_q, last_d;
   logic       m_sel_q, m_sel_d;
   logic       m0_grant_q, m1_grant_q;

`ifdef ARB_TIMEOUT_EN
   logic tc;

   // The hold count restarts on every state change, including a direct
   // handover between masters, so each grant gets its full window.
   arb_hold_counter #(
      .CNT_W  (CNT_W),
      .TC_VAL (TIMEOUT_CYC - 1)
   ) u_hold_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state_d != state_q),
      .enable  (state_q != ARB_IDLE),
      .tc      (tc)
   );
`endif

   // Next-state logic. 'last' and m_sel are derived from the state being
   // entered so they line up with the registered grants; m_sel holds in IDLE
   // to keep the bus lines stable.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      m_sel_d = m_sel_q;

      case (state_q)
         ARB_IDLE: begin
            if (M0_req && M1_req) begin
               state_d = (last_q == MST_M1) ? ARB_GNT_M0 : ARB_GNT_M1;
            end else if (M0_req) begin
               state_d = ARB_GNT_M0;
            end else if (M1_req) begin
               state_d = ARB_GNT_M1;
            end
         end
         ARB_GNT_M0: begin
            if (!M0_req) begin
               state_d = M1_req ? ARB_GNT_M1 : ARB_IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (M1_req && tc) begin
               state_d = ARB_GNT_M1;
            end
`endif
         end
         ARB_GNT_M1: begin
            if (!M1_req) begin
               state_d = M0_req ? ARB_GNT_M0 : ARB_IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (M0_req && tc) begin
               state_d = ARB_GNT_M0;
            end
`endif
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      case (state_d)
         ARB_GNT_M0: begin
            last_d  = MST_M0;
            m_sel_d = 1'b0;
         end
         ARB_GNT_M1: begin
            last_d  = MST_M1;
            m_sel_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // State and registered Moore outputs. Grants decode from a one-hot-style
   // state so both can never be high together; reset clears them at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ARB_IDLE;
         last_q     <= MST_M1;
         m_sel_q    <= 1'b0;
         m0_grant_q <= 1'b0;
         m1_grant_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         m_sel_q    <= m_sel_d;
         m0_grant_q <= (state_d == ARB_GNT_M0);
         m1_grant_q <= (state_d == ARB_GNT_M1);
      end
   end

   assign M0_grant = m0_grant_q;
   assign M1_grant = m1_grant_q;
   assign m_sel    = m_sel_q;
   assign bus_busy = m0_grant_q | m1_grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter: reset, single-master grant, simultaneous
// requests with round-robin, back-to-back alternation, long hold behaviour
// and asynchronous reset mid-grant. Grant exclusivity is watched every cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;

   logic clk;
   logic reset_n;
   logic M0_req;
   logic M1_req;
   logic M0_grant;
   logic M1_grant;
   logic m_sel;
   logic bus_busy;

   int tests_run;
   int tests_failed;

   bus_arbiter dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .M0_req   (M0_req),
      .M1_req   (M1_req),
      .M0_grant (M0_grant),
      .M1_grant (M1_grant),
      .m_sel    (m_sel),
      .bus_busy (bus_busy)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Grants must never overlap, checked on every falling edge.
   always @(negedge clk) begin
      tests_run = tests_run + 1;
      if ((M0_grant & M1_grant) === 1'b1) begin
         tests_failed = tests_failed + 1;
         $display("[TB] FAIL grant_exclusive t=%0t M0_grant=%b M1_grant=%b required not both 1",
                  $time, M0_grant, M1_grant);
      end
   end

   // Advance past the next rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string name, input logic e_m0, input logic e_m1,
                             input logic e_sel, input logic e_busy);
      tests_run = tests_run + 1;
      if ({M0_grant, M1_grant, m_sel, bus_busy} !== {e_m0, e_m1, e_sel, e_busy}) begin
         tests_failed = tests_failed + 1;
         $display("[TB] FAIL %s got m0g=%b m1g=%b sel=%b busy=%b required m0g=%b m1g=%b sel=%b busy=%b",
                  name, M0_grant, M1_grant, m_sel, bus_busy, e_m0, e_m1, e_sel, e_busy);
      end
   endtask

   task automatic do_reset();
      M0_req  = 1'b0;
      M1_req  = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
   endtask

   // Outputs are low during reset and stay low in IDLE after release.
   task automatic test_reset();
      M0_req  = 1'b0;
      M1_req  = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outs("reset_held", 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      tick();
      check_outs("reset_released_idle", 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // A lone M1 request is granted after one edge; m_sel holds on release.
   task automatic test_single_m1();
      M1_req = 1'b1;
      tick();
      check_outs("m1_grant_first", 1'b0, 1'b1, 1'b1, 1'b1);
      repeat (3) begin
         tick();
         check_outs("m1_grant_hold", 1'b0, 1'b1, 1'b1, 1'b1);
      end
      M1_req = 1'b0;
      tick();
      check_outs("m1_release_sel_holds", 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   // From reset (last=M1) simultaneous requests favour M0, then M1 takes
   // over directly when M0 drops.
   task automatic test_simultaneous();
      do_reset();
      M0_req = 1'b1;
      M1_req = 1'b1;
      tick();
      check_outs("both_req_m0_first", 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      check_outs("both_req_m0_stays", 1'b1, 1'b0, 1'b0, 1'b1);
      M0_req = 1'b0;
      tick();
      check_outs("handover_to_m1", 1'b0, 1'b1, 1'b1, 1'b1);
      M1_req = 1'b0;
      tick();
      check_outs("both_released", 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   // Owner releases for one cycle while the other waits: grants alternate.
   // The previous test left last=M1, so M0 wins the first round.
   task automatic test_back_to_back();
      logic owner;
      M0_req = 1'b1;
      M1_req = 1'b1;
      tick();
      owner = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check_outs($sformatf("b2b_xfer%0d", i), ~owner, owner, owner, 1'b1);
         if (owner == 1'b0) M0_req = 1'b0;
         else               M1_req = 1'b0;
         tick();
         if (owner == 1'b0) M0_req = 1'b1;
         else               M1_req = 1'b1;
         owner = ~owner;
      end
      M0_req = 1'b0;
      M1_req = 1'b0;
      tick();
      check_outs("b2b_idle", 1'b0, 1'b0, owner, 1'b0);
   endtask

   // M0 keeps its request while M1 waits. Without the timeout M0 never
   // loses the bus; with it M0 is preempted after TIMEOUT_CYC cycles.
   task automatic test_hold();
      logic e_m0;
      do_reset();
      M0_req = 1'b1;
      tick();
      M1_req = 1'b1;
      for (int k = 1; k <= TIMEOUT_CYC + 4; k++) begin
`ifdef ARB_TIMEOUT_EN
         e_m0 = (k <= TIMEOUT_CYC);
`else
         e_m0 = 1'b1;
`endif
         check_outs($sformatf("hold_cycle%0d", k), e_m0, ~e_m0, ~e_m0, 1'b1);
         tick();
      end
      M0_req = 1'b0;
      tick();
      check_outs("hold_m1_after_release", 1'b0, 1'b1, 1'b1, 1'b1);
      M1_req = 1'b0;
      tick();
      check_outs("hold_idle", 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   // Reset asserted between edges clears the grant without a clock edge.
   task automatic test_async_reset();
      M1_req = 1'b1;
      tick();
      check_outs("async_pre_grant", 1'b0, 1'b1, 1'b1, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check_outs("async_grant_dropped", 1'b0, 1'b0, 1'b0, 1'b0);
      M1_req = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check_outs("async_idle_after", 1'b0, 1'b0, 1'b0, 1'b0);
      M1_req = 1'b1;
      tick();
      check_outs("async_rerequest", 1'b0, 1'b1, 1'b1, 1'b1);
      M1_req = 1'b0;
      tick();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset_n      = 1'b0;
      M0_req       = 1'b0;
      M1_req       = 1'b0;
      test_reset();
      test_single_m1();
      test_simultaneous();
      test_back_to_back();
      test_hold();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
